// File: rtl/ni_packet_injector_pkg.sv
// Shared definitions for the NI injection stage: flit ids, field positions, default widths and FSM states.
// Build option: NI_PARITY_EN (see ni_packet_injector.sv).
package ni_packet_injector_pkg;

  localparam int NI_DATA_WIDTH = 32;
  localparam int NI_AXIS       = 4;
  localparam int NI_LEN_W      = 12;
  localparam int NI_CNT_W      = 16;
  localparam int PE_W          = 28;

  localparam int FID_LSB = 29;
  localparam int LEN_LSB = 17;
  localparam int DST_LSB = 13;
  localparam int SRC_LSB = 9;
  localparam int SEQ_LSB = 1;

  localparam logic [2:0] FID_HEADER = 3'b001;
  localparam logic [2:0] FID_BODY   = 3'b010;
  localparam logic [2:0] FID_TAIL   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } ni_state_e;

  function automatic logic [2:0] payload_fid(input logic is_tail);
    return is_tail ? FID_TAIL : FID_BODY;
  endfunction

endpackage

// File: rtl/ni_packet_injector_parity.sv
// Even-parity generator over the upper flit bits; the result makes the XOR of the whole flit zero.
module flit_parity_gen #(
  parameter int W = 31
) (
  input  logic [W-1:0] data,
  output logic         parity
);

  assign parity = ^data;

endmodule

// File: rtl/ni_packet_injector.sv
// Serialises PE packet requests and payload words into header/body/tail flits for a router Local port.
// Build option: define NI_PARITY_EN to fill bit[0] of every flit with even parity; otherwise bit[0] is 0.
module ni_packet_injector
  import ni_packet_injector_pkg::*;
#(
  parameter int DATA_WIDTH = NI_DATA_WIDTH,
  parameter int AXIS       = NI_AXIS,
  parameter int LEN_W      = NI_LEN_W,
  parameter int CNT_W      = NI_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXIS-1:0]       cur_addr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AXIS-1:0]       req_dst,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  pe_valid,
  output logic                  pe_ready,
  input  logic [PE_W-1:0]       pe_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_drts,
  input  logic                  tx_cts,
  output logic                  busy,
  output logic                  len_err,
  output logic [CNT_W-1:0]      pkt_cnt
);

  ni_state_e             state_reg, state_next;
  logic [AXIS-1:0]       dst_reg;
  logic [LEN_W-1:0]      len_reg;
  logic [LEN_W-1:0]      remaining_reg;
  logic [CNT_W-1:0]      pkt_cnt_reg;
  logic                  len_err_reg;
  logic                  req_ready_reg;
  logic                  busy_reg;
  logic                  tx_drts_reg;
  logic [DATA_WIDTH-1:0] tx_data_reg;

  logic                  req_accept;
  logic                  len_bad;
  logic                  emit;
  logic                  emit_tail;
  logic [DATA_WIDTH-2:0] flit_hi;
  logic [DATA_WIDTH-1:0] flit;

  always_comb begin
    state_next = state_reg;
    req_accept = 1'b0;
    len_bad    = 1'b0;
    emit       = 1'b0;
    emit_tail  = 1'b0;
    flit_hi    = '0;
    unique case (state_reg)
      ST_IDLE: begin
        // req_ready pulses the cycle after an acceptance; ignoring that cycle
        // keeps a still-asserted req_valid from being taken twice.
        if (req_valid && !req_ready_reg) begin
          req_accept = 1'b1;
          if (req_len < LEN_W'(2)) begin
            len_bad = 1'b1;
          end else begin
            state_next = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (tx_cts) begin
          emit       = 1'b1;
          flit_hi    = {FID_HEADER, len_reg, dst_reg, cur_addr, pkt_cnt_reg[7:0]};
          state_next = ST_PAY;
        end
      end
      ST_PAY: begin
        if (tx_cts && pe_valid) begin
          emit      = 1'b1;
          emit_tail = (remaining_reg == LEN_W'(1));
          flit_hi   = {payload_fid(emit_tail), pe_data};
          if (emit_tail) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef NI_PARITY_EN
  logic parity_bit;

  flit_parity_gen #(
    .W(DATA_WIDTH - 1)
  ) u_parity (
    .data   (flit_hi),
    .parity (parity_bit)
  );

  assign flit = {flit_hi, parity_bit};
`else
  assign flit = {flit_hi, 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      dst_reg       <= '0;
      len_reg       <= '0;
      remaining_reg <= '0;
      pkt_cnt_reg   <= '0;
      len_err_reg   <= 1'b0;
      req_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      tx_drts_reg   <= 1'b0;
      tx_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= req_accept;
      tx_drts_reg   <= emit;
      // busy covers the tail cycle itself and falls one cycle later
      busy_reg      <= (state_next != ST_IDLE) || emit_tail;
      if (len_bad) begin
        len_err_reg <= 1'b1;
      end
      if (req_accept && !len_bad) begin
        dst_reg       <= req_dst;
        len_reg       <= req_len;
        remaining_reg <= req_len - LEN_W'(1);
      end
      if (emit) begin
        tx_data_reg <= flit;
      end
      if (emit && state_reg == ST_PAY) begin
        remaining_reg <= remaining_reg - LEN_W'(1);
      end
      if (emit_tail) begin
        pkt_cnt_reg <= pkt_cnt_reg + CNT_W'(1);
      end
    end
  end

  // pe_ready follows tx_cts directly so a word is consumed exactly when its flit goes out
  assign pe_ready  = (state_reg == ST_PAY) && tx_cts;
  assign req_ready = req_ready_reg;
  assign tx_drts   = tx_drts_reg;
  assign tx_data   = tx_data_reg;
  assign busy      = busy_reg;
  assign len_err   = len_err_reg;
  assign pkt_cnt   = pkt_cnt_reg;

endmodule

// File: tb/tb_ni_packet_injector.sv
// Directed bench for ni_packet_injector: vector table for packets/backpressure/illegal length,
// hand sequences for reset mid-packet and a random parity sweep.
module tb_ni_packet_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cur_addr;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_dst;
  logic [11:0] req_len;
  logic        pe_valid;
  logic        pe_ready;
  logic [27:0] pe_data;
  logic [31:0] tx_data;
  logic        tx_drts;
  logic        tx_cts;
  logic        busy;
  logic        len_err;
  logic [15:0] pkt_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int flit_seen = 0;

  always #5 clk = ~clk;

  ni_packet_injector dut (
    .clk       (clk),
    .rst       (rst),
    .cur_addr  (cur_addr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dst   (req_dst),
    .req_len   (req_len),
    .pe_valid  (pe_valid),
    .pe_ready  (pe_ready),
    .pe_data   (pe_data),
    .tx_data   (tx_data),
    .tx_drts   (tx_drts),
    .tx_cts    (tx_cts),
    .busy      (busy),
    .len_err   (len_err),
    .pkt_cnt   (pkt_cnt)
  );

  typedef struct {
    logic        req_valid;
    logic [3:0]  dst;
    logic [11:0] len;
    logic        pe_valid;
    logic [27:0] pe_data;
    logic        cts;
    logic        exp_pe_ready;
    logic        exp_drts;
    logic [31:0] exp_data;
    logic        exp_req_ready;
    logic        exp_busy;
    logic [15:0] exp_cnt;
    logic        exp_len_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Table values are written with bit[0]=0; add parity when the option is built in.
  function automatic logic [31:0] with_par(input logic [31:0] x);
`ifdef NI_PARITY_EN
    return {x[31:1], ^x[31:1]};
`else
    return x;
`endif
  endfunction

  always @(negedge clk) begin
    if (tx_drts === 1'b1) begin
      flit_seen++;
`ifdef NI_PARITY_EN
      chk("flit_parity_xor", {31'd0, ^tx_data}, 32'd0);
`else
      chk("flit_bit0_zero", {31'd0, tx_data[0]}, 32'd0);
`endif
    end
  end

  function automatic vec_t mk(input logic rv, input logic [3:0] d, input logic [11:0] l,
                              input logic pv, input logic [27:0] pd, input logic c,
                              input logic epr, input logic ed, input logic [31:0] edata,
                              input logic err, input logic eb, input logic [15:0] ec,
                              input logic ele);
    vec_t v;
    v = '{rv, d, l, pv, pd, c, epr, ed, edata, err, eb, ec, ele};
    return v;
  endfunction

  task automatic wait_drts(input int max_cycles, input string name);
    int k;
    k = 0;
    while (tx_drts !== 1'b1 && k < max_cycles) begin
      @(posedge clk); #1;
      k++;
    end
    if (tx_drts !== 1'b1) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < max_cycles) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy !== 1'b0) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int base_flits;
    int exp_flits;
    logic [15:0] base_cnt;

    rst = 1'b1; cur_addr = 4'd0; req_valid = 1'b0; req_dst = '0; req_len = '0;
    pe_valid = 1'b0; pe_data = '0; tx_cts = 1'b1;

    // Packet 1: dst 3, len 3, full-rate
    vecs.push_back(mk(1, 3, 3, 0, 28'h0,       1, 0, 0, 32'h0,         1, 1, 16'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       1, 0, 1, 32'h2006_6000, 0, 1, 16'd0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 28'h0000ABC, 1, 1, 1, 32'h4000_1578, 0, 1, 16'd0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 28'h0000DEF, 1, 1, 1, 32'h8000_1BDE, 0, 1, 16'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       1, 0, 0, 32'h0,         0, 0, 16'd1, 0));
    // Packet 2: dst 5, len 3, 5-cycle backpressure after the header, one pe_valid gap
    vecs.push_back(mk(1, 5, 3, 0, 28'h0,       1, 0, 0, 32'h0,         1, 1, 16'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       1, 0, 1, 32'h2006_A002, 0, 1, 16'd1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 1, 28'h1234567, 0, 0, 0, 32'h0,       0, 1, 16'd1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 28'h1234567, 1, 1, 1, 32'h4246_8ACE, 0, 1, 16'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       1, 1, 0, 32'h0,         0, 1, 16'd1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 28'hFEDCBA9, 1, 1, 1, 32'h9FDB_9752, 0, 1, 16'd2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       1, 0, 0, 32'h0,         0, 0, 16'd2, 0));
    // Illegal length, then a legal len-2 packet, then back-to-back len-2 packet
    vecs.push_back(mk(1, 1, 1, 0, 28'h0,       1, 0, 0, 32'h0,         1, 0, 16'd2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       1, 0, 0, 32'h0,         0, 0, 16'd2, 1));
    vecs.push_back(mk(1, 7, 2, 0, 28'h0,       1, 0, 0, 32'h0,         1, 1, 16'd2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       1, 0, 1, 32'h2004_E004, 0, 1, 16'd2, 1));
    vecs.push_back(mk(0, 0, 0, 1, 28'h0000001, 1, 1, 1, 32'h8000_0002, 0, 1, 16'd3, 1));
    vecs.push_back(mk(1, 2, 2, 0, 28'h0,       1, 0, 0, 32'h0,         1, 1, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       1, 0, 1, 32'h2004_4006, 0, 1, 16'd3, 1));
    vecs.push_back(mk(0, 0, 0, 1, 28'hFFFFFFF, 1, 1, 1, 32'h9FFF_FFFE, 0, 1, 16'd4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       1, 0, 0, 32'h0,         0, 0, 16'd4, 1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_drts",   {31'd0, tx_drts},   32'd0);
    chk("rst_tx_data",   tx_data,            32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_pe_ready",  {31'd0, pe_ready},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_len_err",   {31'd0, len_err},   32'd0);
    chk("rst_pkt_cnt",   {16'd0, pkt_cnt},   32'd0);
    $display("reset: drts=%b data=%h busy=%b cnt=%0d", tx_drts, tx_data, busy, pkt_cnt);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_no_drts", {31'd0, tx_drts}, 32'd0);
    end
    $display("idle: 20 cycles with tx_cts=1, no request");

    foreach (vecs[i]) begin
      req_valid = vecs[i].req_valid;
      req_dst   = vecs[i].dst;
      req_len   = vecs[i].len;
      pe_valid  = vecs[i].pe_valid;
      pe_data   = vecs[i].pe_data;
      tx_cts    = vecs[i].cts;
      #1;
      chk($sformatf("v%0d_pe_ready", i), {31'd0, pe_ready}, {31'd0, vecs[i].exp_pe_ready});
      @(posedge clk); #1;
      chk($sformatf("v%0d_drts", i), {31'd0, tx_drts}, {31'd0, vecs[i].exp_drts});
      if (vecs[i].exp_drts)
        chk($sformatf("v%0d_data", i), tx_data, with_par(vecs[i].exp_data));
      chk($sformatf("v%0d_req_ready", i), {31'd0, req_ready}, {31'd0, vecs[i].exp_req_ready});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      chk($sformatf("v%0d_pkt_cnt", i), {16'd0, pkt_cnt}, {16'd0, vecs[i].exp_cnt});
      chk($sformatf("v%0d_len_err", i), {31'd0, len_err}, {31'd0, vecs[i].exp_len_err});
      $display("vec %0d: rv=%b len=%0d pv=%b cts=%b -> drts=%b data=%h rr=%b busy=%b cnt=%0d err=%b",
               i, vecs[i].req_valid, vecs[i].len, vecs[i].pe_valid, vecs[i].cts,
               tx_drts, tx_data, req_ready, busy, pkt_cnt, len_err);
    end
    req_valid = 1'b0; pe_valid = 1'b0; tx_cts = 1'b1;

    // Reset mid-packet: len-5 packet abandoned right after its header
    req_valid = 1'b1; req_dst = 4'd4; req_len = 12'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drts(10, "midrst_hdr");
    chk("midrst_hdr_data", tx_data, with_par(32'h200A_8008));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_drts",    {31'd0, tx_drts}, 32'd0);
    chk("midrst_busy",    {31'd0, busy},    32'd0);
    chk("midrst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    chk("midrst_len_err", {31'd0, len_err}, 32'd0);
    $display("mid-packet reset: drts=%b busy=%b cnt=%0d", tx_drts, busy, pkt_cnt);

    req_valid = 1'b1; req_dst = 4'd1; req_len = 12'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drts(10, "post_rst_hdr");
    chk("post_rst_hdr_data", tx_data, with_par(32'h2004_2000));
    pe_valid = 1'b1; pe_data = 28'h5555555;
    @(posedge clk); #1;
    pe_valid = 1'b0;
    chk("post_rst_tail_drts", {31'd0, tx_drts}, 32'd1);
    chk("post_rst_tail_data", tx_data, with_par(32'h8AAA_AAAA));
    chk("post_rst_pkt_cnt",   {16'd0, pkt_cnt}, 32'd1);
    $display("post-reset packet: tail=%h cnt=%0d", tx_data, pkt_cnt);
    wait_idle(10, "post_rst_idle");

    // Random packets: parity/bit0 checked by the flit monitor, flit and packet totals here
    base_flits = flit_seen;
    base_cnt   = pkt_cnt;
    exp_flits  = 0;
    for (int p = 0; p < 100; p++) begin
      int words;
      int idx;
      int guard;
      logic take;
      wait_idle(50, "rand_idle");
      req_valid = 1'b1;
      req_dst   = 4'($urandom_range(0, 15));
      req_len   = 12'($urandom_range(2, 6));
      cur_addr  = 4'($urandom_range(0, 15));
      words     = int'(req_len) - 1;
      exp_flits += int'(req_len);
      @(posedge clk); #1;
      req_valid = 1'b0;
      idx = 0;
      guard = 0;
      while (idx < words && guard < 300) begin
        tx_cts   = 1'($urandom_range(0, 1));
        pe_valid = ($urandom_range(0, 3) != 0);
        pe_data  = 28'($urandom);
        #1;
        take = pe_ready && pe_valid;
        @(posedge clk); #1;
        if (take) idx++;
        guard++;
      end
      if (idx < words) chk("rand_payload_timeout", 32'(idx), 32'(words));
      pe_valid = 1'b0;
      tx_cts   = 1'b1;
    end
    @(posedge clk); #1;
    wait_idle(50, "rand_final_idle");
    chk("rand_flit_total", 32'(flit_seen - base_flits), 32'(exp_flits));
    chk("rand_pkt_total",  {16'd0, pkt_cnt - base_cnt}, 32'd100);
    $display("random: %0d packets, %0d flits", pkt_cnt - base_cnt, flit_seen - base_flits);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
